// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: one power-of-two shift step per register stage, with a
// valid/ready handshake on both sides and a tag carried through alongside each operation.
module pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_ROL = 3'd1;
    localparam logic [2:0] MODE_SRL = 3'd2;
    localparam logic [2:0] MODE_SRA = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d, input int s,
                                                    input logic [2:0] mode);
        logic signed [WIDTH-1:0] ds;
        logic [WIDTH-1:0]        r;
        ds = d;
        case (mode)
            MODE_SLL: r = d << s;
            MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
            MODE_SRL: r = d >> s;
            MODE_SRA: r = ds >>> s;
            MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
            default:  r = d;
        endcase
        return r;
    endfunction

    // The last bit leaving this step is also the last bit leaving the whole shift,
    // since earlier stages only moved the operand by smaller amounts.
    function automatic logic shift_carry(input logic [WIDTH-1:0] d, input int s,
                                         input logic [2:0] mode);
        logic [WIDTH-1:0] t;
        if (mode == MODE_SLL || mode == MODE_ROL)
            t = d >> (WIDTH - s);
        else
            t = d >> (s - 1);
        return t[0];
    endfunction

    logic             vld_q   [AMT_W];
    logic [WIDTH-1:0] data_q  [AMT_W];
    logic [AMT_W-1:0] amt_q   [AMT_W];
    logic [2:0]       mode_q  [AMT_W];
    logic [TAG_W-1:0] tag_q   [AMT_W];
    logic             carry_q [AMT_W];
    logic             err_q   [AMT_W];

    logic             vld_d   [AMT_W];
    logic [WIDTH-1:0] data_d  [AMT_W];
    logic [AMT_W-1:0] amt_d   [AMT_W];
    logic [2:0]       mode_d  [AMT_W];
    logic [TAG_W-1:0] tag_d   [AMT_W];
    logic             carry_d [AMT_W];
    logic             err_d   [AMT_W];

    logic             src_vld   [AMT_W];
    logic [WIDTH-1:0] src_data  [AMT_W];
    logic [AMT_W-1:0] src_amt   [AMT_W];
    logic [2:0]       src_mode  [AMT_W];
    logic [TAG_W-1:0] src_tag   [AMT_W];
    logic             src_carry [AMT_W];
    logic             src_err   [AMT_W];

    logic stall;

    always_comb begin
        stall = vld_q[AMT_W-1] && !out_ready;

        src_vld[0]   = in_valid;
        src_data[0]  = in_data;
        src_amt[0]   = in_amt;
        src_mode[0]  = in_mode;
        src_tag[0]   = in_tag;
        src_carry[0] = 1'b0;
        src_err[0]   = in_mode > MODE_ROR;
        for (int k = 1; k < AMT_W; k++) begin
            src_vld[k]   = vld_q[k-1];
            src_data[k]  = data_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_err[k]   = err_q[k-1];
        end

        for (int k = 0; k < AMT_W; k++) begin
            vld_d[k]   = vld_q[k];
            data_d[k]  = data_q[k];
            amt_d[k]   = amt_q[k];
            mode_d[k]  = mode_q[k];
            tag_d[k]   = tag_q[k];
            carry_d[k] = carry_q[k];
            err_d[k]   = err_q[k];
            if (!stall) begin
                vld_d[k]   = src_vld[k];
                data_d[k]  = src_data[k];
                amt_d[k]   = src_amt[k];
                mode_d[k]  = src_mode[k];
                tag_d[k]   = src_tag[k];
                carry_d[k] = src_carry[k];
                err_d[k]   = src_err[k];
                if (src_amt[k][k] && !src_err[k]) begin
                    data_d[k]  = shift_data(src_data[k], 1 << k, src_mode[k]);
                    carry_d[k] = shift_carry(src_data[k], 1 << k, src_mode[k]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < AMT_W; k++) begin
            if (!rst_n) begin
                vld_q[k]   <= 1'b0;
                data_q[k]  <= '0;
                amt_q[k]   <= '0;
                mode_q[k]  <= '0;
                tag_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                err_q[k]   <= 1'b0;
            end else begin
                vld_q[k]   <= vld_d[k];
                data_q[k]  <= data_d[k];
                amt_q[k]   <= amt_d[k];
                mode_q[k]  <= mode_d[k];
                tag_q[k]   <= tag_d[k];
                carry_q[k] <= carry_d[k];
                err_q[k]   <= err_d[k];
            end
        end
    end

    // Outputs are forced to their idle values whenever no result is presented.
    always_comb begin
        in_ready  = !stall;
        out_valid = vld_q[AMT_W-1];
        out_data  = out_valid ? data_q[AMT_W-1] : '0;
        out_carry = out_valid && carry_q[AMT_W-1];
        out_err   = out_valid && err_q[AMT_W-1];
        out_tag   = out_valid ? tag_q[AMT_W-1] : '0;
        out_zero  = (out_data == '0);
    end

endmodule
